bucket_update: RTL and testbench

Final stage of the heavy-hitter datapath, directly downstream of the merge queue. Consumes merged (item, counter) pairs, hashes each item to one bucket of an on-chip table, and performs a pipelined read-modify-write: add on key match, insert into an empty bucket, or decrement/replace on collision. When a stored key loses its bucket, the block reports it on an eviction port. It also drives the queue's `output_ready`.

---
 rtl/bucket_update.sv | 243 ++++++++++++++++++++++++
 tb/tb_bucket_update.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bucket_update.sv
// bucket_update
// -----------------------------------------------------------------------------
// Final stage of the heavy-hitter datapath. Takes merged (item, counter) pairs,
// hashes each item to one bucket of an on-chip table, and performs a
// three-stage pipelined read-modify-write:
//   - add on key match
//   - insert into an empty bucket
//   - decrement, or replace, on a collision
// A stored key that loses its bucket is reported on the eviction port.
//
// Build option:
//   BUCKET_UPDATE_SAT_EN  when defined, the match-path add saturates at
//                         all-ones; otherwise it wraps.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   valid_in         merged item present (ignored until the table is cleared)
//   item_in          item key
//   item_counter_in  merged count
//   ready_out        high once the table clear is finished (RUN state)
//   init_done        same condition as ready_out
//   evict_valid      one-cycle pulse: a stored key was displaced
//   evict_item       displaced key (0 when no eviction this cycle)
//   evict_counter    displaced key's count (0 when no eviction this cycle)
// -----------------------------------------------------------------------------
module bucket_update #(
    parameter int ITEM_LENGTH       = 30,
    parameter int ITEM_COUNTER_SIZE = 12,
    parameter int BUCKET_COUNT      = 256,
    parameter int BUCKET_CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    input  logic [ITEM_LENGTH-1:0]       item_in,
    input  logic [ITEM_COUNTER_SIZE-1:0] item_counter_in,
    output logic                         ready_out,
    output logic                         init_done,
    output logic                         evict_valid,
    output logic [ITEM_LENGTH-1:0]       evict_item,
    output logic [BUCKET_CNT_WIDTH-1:0]  evict_counter
);
    localparam int IDX_W   = $clog2(BUCKET_COUNT);
    localparam int NCHUNK  = (ITEM_LENGTH + IDX_W - 1) / IDX_W;
    localparam int ENTRY_W = 1 + ITEM_LENGTH + BUCKET_CNT_WIDTH;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    clr_ptr_q, clr_ptr_d;
    logic                run;
    logic                accept;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_INIT) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == '1) begin
                state_d = ST_RUN;
            end
        end
    end

    assign run       = (state_q == ST_RUN);
    assign ready_out = run;
    assign init_done = run;
    assign accept    = valid_in && run;

    // ---------------- hash: XOR of IDX_W-bit chunks ----------------
    logic [NCHUNK*IDX_W-1:0] item_pad;
    logic [IDX_W-1:0]        chunk [NCHUNK];
    logic [IDX_W-1:0]        hash_idx;

    // The top chunk may be partial; padding with zeros zero-extends it.
    always_comb begin
        item_pad                  = '0;
        item_pad[ITEM_LENGTH-1:0] = item_in;
    end

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign chunk[gi] = item_pad[gi*IDX_W +: IDX_W];
        end
    endgenerate

    always_comb begin
        hash_idx = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            hash_idx = hash_idx ^ chunk[i];
        end
    end

    // ---------------- stage 1: index / key ----------------
    logic                        s1_vld_q;
    logic [IDX_W-1:0]            s1_idx_q;
    logic [ITEM_LENGTH-1:0]      s1_key_q;
    logic [BUCKET_CNT_WIDTH-1:0] s1_inc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            s1_key_q <= '0;
            s1_inc_q <= '0;
        end else begin
            s1_vld_q <= accept;
            s1_idx_q <= hash_idx;
            s1_key_q <= item_in;
            s1_inc_q <= BUCKET_CNT_WIDTH'(item_counter_in);
        end
    end

    // ---------------- bucket table ----------------
    logic [ENTRY_W-1:0] table_q [BUCKET_COUNT];
    logic               tbl_we;
    logic [IDX_W-1:0]   tbl_addr;
    logic [ENTRY_W-1:0] tbl_wdata;
    logic [ENTRY_W-1:0] upd_entry;

    // ---------------- stage 2: bucket data ----------------
    logic                        s2_vld_q;
    logic [IDX_W-1:0]            s2_idx_q;
    logic [ITEM_LENGTH-1:0]      s2_key_q;
    logic [BUCKET_CNT_WIDTH-1:0] s2_inc_q;
    logic [ENTRY_W-1:0]          s2_ent_q, s2_ent_d;

    // The write issued on this edge is not yet in the table, so a read of the
    // same bucket takes the write data instead. This lets consecutive items
    // hit one bucket with no stall.
    always_comb begin
        s2_ent_d = table_q[s1_idx_q];
        if (s2_vld_q && (s2_idx_q == s1_idx_q)) begin
            s2_ent_d = upd_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
            s2_idx_q <= '0;
            s2_key_q <= '0;
            s2_inc_q <= '0;
            s2_ent_q <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            s2_idx_q <= s1_idx_q;
            s2_key_q <= s1_key_q;
            s2_inc_q <= s1_inc_q;
            s2_ent_q <= s2_ent_d;
        end
    end

    // ---------------- update decision ----------------
    logic                        b_vld;
    logic [ITEM_LENGTH-1:0]      b_key;
    logic [BUCKET_CNT_WIDTH-1:0] b_cnt;
    logic [BUCKET_CNT_WIDTH:0]   sum_ext;
    logic [BUCKET_CNT_WIDTH-1:0] add_cnt;
    logic                        do_evict;

    assign b_vld   = s2_ent_q[ENTRY_W-1];
    assign b_key   = s2_ent_q[BUCKET_CNT_WIDTH +: ITEM_LENGTH];
    assign b_cnt   = s2_ent_q[BUCKET_CNT_WIDTH-1:0];
    assign sum_ext = {1'b0, b_cnt} + {1'b0, s2_inc_q};

`ifdef BUCKET_UPDATE_SAT_EN
    assign add_cnt = sum_ext[BUCKET_CNT_WIDTH] ? '1 : sum_ext[BUCKET_CNT_WIDTH-1:0];
`else
    assign add_cnt = sum_ext[BUCKET_CNT_WIDTH-1:0];
`endif

    // Default is the "incoming loses" collision: decrement, keep the key.
    // Both subtractions only happen when the minuend is the larger value.
    always_comb begin
        upd_entry = {1'b1, b_key, b_cnt - s2_inc_q};
        do_evict  = 1'b0;
        if (!b_vld) begin
            upd_entry = {1'b1, s2_key_q, s2_inc_q};
        end else if (b_key == s2_key_q) begin
            upd_entry = {1'b1, b_key, add_cnt};
        end else if (s2_inc_q > b_cnt) begin
            upd_entry = {1'b1, s2_key_q, s2_inc_q - b_cnt};
            do_evict  = 1'b1;
        end
    end

    // Single write port, shared by the clear sweep and the update path.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_addr  = s2_idx_q;
        tbl_wdata = upd_entry;
        if (state_q == ST_INIT) begin
            tbl_we    = 1'b1;
            tbl_addr  = clr_ptr_q;
            tbl_wdata = '0;
        end else if (s2_vld_q) begin
            tbl_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            table_q[tbl_addr] <= tbl_wdata;
        end
    end

    // ---------------- eviction port ----------------
    logic                        evict_valid_q;
    logic [ITEM_LENGTH-1:0]      evict_item_q;
    logic [BUCKET_CNT_WIDTH-1:0] evict_counter_q;
    logic                        evict_now;

    assign evict_now = s2_vld_q && do_evict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evict_valid_q   <= 1'b0;
            evict_item_q    <= '0;
            evict_counter_q <= '0;
        end else begin
            evict_valid_q   <= evict_now;
            evict_item_q    <= evict_now ? b_key : '0;
            evict_counter_q <= evict_now ? b_cnt : '0;
        end
    end

    assign evict_valid   = evict_valid_q;
    assign evict_item    = evict_item_q;
    assign evict_counter = evict_counter_q;

endmodule

// File: tb/tb_bucket_update.sv
module tb_bucket_update;
    localparam int NB = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [29:0] item_in = '0;
    logic [11:0] item_counter_in = '0;
    logic        ready_out, init_done, evict_valid;
    logic [29:0] evict_item;
    logic [15:0] evict_counter;

    bucket_update dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .item_in(item_in),
        .item_counter_in(item_counter_in), .ready_out(ready_out),
        .init_done(init_done), .evict_valid(evict_valid),
        .evict_item(evict_item), .evict_counter(evict_counter)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: buckets updated in acceptance order.
    logic        m_vld [NB];
    logic [29:0] m_key [NB];
    logic [15:0] m_cnt [NB];
    int          m_edges;          // edges since reset release
    logic [46:0] p1, p2;           // expected eviction words, 1 and 2 edges old

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int model_hash(input logic [29:0] key);
        int idx = 0;
        for (int s = 0; s < 30; s += 8) idx = idx ^ int'((key >> s) & 30'hFF);
        return idx;
    endfunction

    function automatic logic [46:0] model_apply(input logic [29:0] key, input logic [11:0] c);
        int idx = model_hash(key);
        int inc = int'(c);
        int cur = int'(m_cnt[idx]);
        int sum;
        logic [46:0] ev = '0;
        if (!m_vld[idx]) begin
            m_vld[idx] = 1'b1; m_key[idx] = key; m_cnt[idx] = 16'(inc);
        end else if (m_key[idx] == key) begin
            sum = cur + inc;
`ifdef BUCKET_UPDATE_SAT_EN
            if (sum > 65535) sum = 65535;
`endif
            m_cnt[idx] = 16'(sum % 65536);
        end else if (inc > cur) begin
            ev = {1'b1, m_key[idx], m_cnt[idx]};
            m_key[idx] = key; m_cnt[idx] = 16'(inc - cur);
        end else begin
            m_cnt[idx] = 16'(cur - inc);
        end
        return ev;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_vld[i] = 1'b0; m_key[i] = '0; m_cnt[i] = '0;
        end
        m_edges = 0; p1 = '0; p2 = '0;
    endtask

    // One clock cycle: drive, advance, check ready and eviction port.
    task automatic step(input logic v, input logic [29:0] it, input logic [11:0] c);
        logic        acc;
        logic [46:0] cur;
        valid_in = v; item_in = it; item_counter_in = c;
        acc = v && (m_edges >= NB);
        @(posedge clk);
        if (m_edges < NB) m_edges++;
        cur = acc ? model_apply(it, c) : 47'd0;
        #1;
        chk("ready", {ready_out, init_done}, (m_edges >= NB) ? 2'b11 : 2'b00);
        chk("evict", {evict_valid, evict_item, evict_counter}, p2);
        p2 = p1; p1 = cur;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 30'd0, 12'd0);
    endtask

    task automatic chk_table(input string tag);
        logic [46:0] ent;
        for (int i = 0; i < NB; i++) begin
            ent = dut.table_q[i];
            chk(tag, ent, {m_vld[i], m_key[i], m_cnt[i]});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid_in = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_outs", {ready_out, init_done, evict_valid, evict_item, evict_counter}, 64'd0);
        end
        rst_n = 1'b1;
    endtask

    logic [46:0] ent;
    logic [29:0] rkey;

    initial begin
        do_reset();

        // INIT with valid_in held high: nothing accepted, ready at edge 256.
        for (int i = 0; i < NB; i++) step(1'b1, 30'($urandom), 12'($urandom));
        chk_table("init_empty");

        // Insert then match.
        step(1'b1, 30'h5, 12'd3);
        idle(1);
        step(1'b1, 30'h5, 12'd4);
        idle(2);
        ent = dut.table_q[5];
        chk("match_b5", ent, {1'b1, 30'h5, 16'd7});

        // Collision on index 7 (0x10107 hashes to 7): decrement, then replace.
        step(1'b1, 30'h7, 12'd3);
        step(1'b1, 30'h10107, 12'd2);
        idle(2);
        ent = dut.table_q[7];
        chk("decr_b7", ent, {1'b1, 30'h7, 16'd1});
        step(1'b1, 30'h10107, 12'd9);
        idle(1);
        chk("evict_early", evict_valid, 1'b0);
        idle(1);
        chk("evict_pulse", {evict_valid, evict_item, evict_counter}, {1'b1, 30'h7, 16'd1});
        idle(1);
        chk("evict_clear", {evict_valid, evict_item, evict_counter}, 47'd0);
        ent = dut.table_q[7];
        chk("repl_b7", ent, {1'b1, 30'h10107, 16'd8});

        // Back-to-back same bucket exercises forwarding.
        for (int i = 0; i < 3; i++) step(1'b1, 30'hA, 12'd1);
        idle(2);
        ent = dut.table_q[10];
        chk("fwd_bA", ent, {1'b1, 30'hA, 16'd3});

        // Preload 0xFFF0 (16 x 0xFFF), then add 0x20.
        for (int i = 0; i < 16; i++) step(1'b1, 30'h20, 12'hFFF);
        idle(2);
        ent = dut.table_q[32];
        chk("preload", ent, {1'b1, 30'h20, 16'hFFF0});
        step(1'b1, 30'h20, 12'h020);
        idle(2);
        ent = dut.table_q[32];
`ifdef BUCKET_UPDATE_SAT_EN
        chk("sat_add", ent, {1'b1, 30'h20, 16'hFFFF});
`else
        chk("wrap_add", ent, {1'b1, 30'h20, 16'h0010});
`endif

        // Random traffic over a few crowded buckets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) rkey = 30'($urandom);
            else rkey = 30'(($urandom_range(0, 7) << 16) | $urandom_range(0, 7));
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, rkey, 12'($urandom));
        end
        idle(2);
        chk_table("rand_table");

        // Reset with an eviction in flight (0x10130 collides with 0x30).
        step(1'b1, 30'h30, 12'd1);
        idle(2);
        step(1'b1, 30'h10130, 12'd5);
        do_reset();
        for (int i = 0; i < NB; i++) step(1'b1, 30'h10130, 12'd5);
        chk_table("reinit_empty");
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end
endmodule
